// File: rtl/rv_plic_claim_master.sv
// Claim/complete sequencer for one PLIC target: claims an interrupt ID through the CC
// register, hands it to a consumer, then writes the ID back once the handler completes.
module rv_plic_claim_master #(
   parameter type         reg_req_t   = logic,
   parameter type         reg_rsp_t   = logic,
   parameter int unsigned SRCW        = 6,
   parameter logic [31:0] CcAddr      = 32'h0020_0004,
   parameter int unsigned GuardCycles = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            irq_i,
   output reg_req_t        reg_req_o,
   input  reg_rsp_t        reg_rsp_i,
   output logic            claim_valid_o,
   output logic [SRCW-1:0] claim_id_o,
   input  logic            claim_ready_i,
   input  logic            complete_valid_i,
   input  logic [SRCW-1:0] complete_id_i,
   output logic            complete_ready_o,
   output logic            err_o,
   output logic [15:0]     spurious_cnt_o,
   output logic            busy_o
);

   // Local views of the bus structs; field order matches the register-interface packing.
   typedef struct packed {
      logic [31:0] addr;
      logic        write;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic        valid;
   } req_bits_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic        error;
      logic        ready;
   } rsp_bits_t;

   localparam int unsigned    GcW    = (GuardCycles > 1) ? $clog2(GuardCycles) : 1;
   localparam logic [GcW-1:0] GcLast = (GuardCycles > 0) ? GcW'(GuardCycles - 1) : '0;

   typedef enum logic [2:0] {
      StIdle,
      StClaimRd,
      StDeliver,
      StWaitCmpl,
      StCmplWr,
      StGuard
   } state_e;

   state_e          state_q, state_d;
   logic [SRCW-1:0] id_q, id_d;
   logic [GcW-1:0]  gc_q, gc_d;
   logic [15:0]     spurious_cnt_q, spurious_cnt_d;
   logic            err_q, err_d;

   rsp_bits_t       rsp;
   req_bits_t       req;
   logic [SRCW-1:0] rd_id;
   logic            unused_rdata;

   assign rsp          = rsp_bits_t'(reg_rsp_i);
   assign rd_id        = rsp.rdata[SRCW-1:0];
   assign unused_rdata = ^rsp.rdata;

   always_comb begin
      state_d        = state_q;
      id_d           = id_q;
      gc_d           = gc_q;
      spurious_cnt_d = spurious_cnt_q;
      err_d          = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (irq_i) state_d = StClaimRd;
         end
         StClaimRd: begin
            if (rsp.ready) begin
               if (rsp.error) begin
                  err_d   = 1'b1;
                  state_d = StIdle;
               end else begin
                  id_d = rd_id;
                  if (rd_id != '0) begin
                     state_d = StDeliver;
                  end else begin
                     state_d = StIdle;
                     if (spurious_cnt_q != 16'hFFFF) spurious_cnt_d = spurious_cnt_q + 16'd1;
                  end
               end
            end
         end
         StDeliver: begin
            if (claim_ready_i) state_d = StWaitCmpl;
         end
         StWaitCmpl: begin
            if (complete_valid_i) begin
               state_d = StCmplWr;
               err_d   = (complete_id_i != id_q);
            end
         end
         StCmplWr: begin
            if (rsp.ready) begin
               err_d   = rsp.error;
               gc_d    = '0;
               state_d = (GuardCycles == 0) ? StIdle : StGuard;
            end
         end
         StGuard: begin
            // irq_i is deliberately not looked at here; the PLIC needs time to drop it.
            if (gc_q == GcLast) state_d = StIdle;
            else gc_d = gc_q + GcW'(1);
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q        <= StIdle;
         id_q           <= '0;
         gc_q           <= '0;
         spurious_cnt_q <= '0;
         err_q          <= 1'b0;
      end else begin
         state_q        <= state_d;
         id_q           <= id_d;
         gc_q           <= gc_d;
         spurious_cnt_q <= spurious_cnt_d;
         err_q          <= err_d;
      end
   end

   // Bus request decoded purely from the state register.
   always_comb begin
      req = '0;
      if (state_q == StClaimRd) begin
         req.valid = 1'b1;
         req.addr  = CcAddr;
      end else if (state_q == StCmplWr) begin
         req.valid = 1'b1;
         req.write = 1'b1;
         req.addr  = CcAddr;
         req.wstrb = 4'hF;
         req.wdata = 32'(id_q);
      end
   end

   assign reg_req_o        = reg_req_t'(req);
   assign claim_valid_o    = (state_q == StDeliver);
   assign claim_id_o       = (state_q == StDeliver) ? id_q : '0;
   assign complete_ready_o = (state_q == StWaitCmpl);
   assign err_o            = err_q;
   assign spurious_cnt_o   = spurious_cnt_q;
   assign busy_o           = (state_q != StIdle);

endmodule
